// File: rtl/scroll_window_gen_if.sv
// Bus bundle for scroll_window_gen: scroll controls in, position/window/pulses out.
interface scroll_window_gen_if #(
  parameter int MSG_LEN  = 8,
  parameter int NUM_DISP = 6
);
  localparam int IW = (MSG_LEN <= 2) ? 1 : $clog2(MSG_LEN);

  logic                     En;
  logic                     Dir;
  logic                     Bounce;
  logic                     Load;
  logic [IW-1:0]            LoadPos;
  logic [IW-1:0]            Pos;
  logic [NUM_DISP*IW-1:0]   Win;
  logic                     Step;
  logic                     Wrap;

  modport master (
    output En, Dir, Bounce, Load, LoadPos,
    input  Pos, Win, Step, Wrap
  );

  modport slave (
    input  En, Dir, Bounce, Load, LoadPos,
    output Pos, Win, Step, Wrap
  );
endinterface

// File: rtl/scroll_window_gen.sv
// Scroll-position generator for multi-digit seven-segment message displays.
// A prescaler turns DIV enabled clocks into one scroll step; the position moves
// in wrap or ping-pong fashion and Win lists the character index per digit.
module scroll_window_gen #(
  parameter int MSG_LEN  = 8,
  parameter int NUM_DISP = 6,
  parameter int DIV      = 25_000_000
) (
  input  logic               Clock,
  input  logic               Clr,
  scroll_window_gen_if.slave bus
);
  localparam int IW = (MSG_LEN <= 2) ? 1 : $clog2(MSG_LEN);
  localparam int PW = (DIV <= 2) ? 1 : $clog2(DIV);

  localparam logic [IW-1:0] POS_LAST = IW'(MSG_LEN - 1);
  // Turn-around target when bouncing off the top end (unused when MSG_LEN == 1).
  localparam logic [IW-1:0] POS_TURN = IW'((MSG_LEN >= 2) ? (MSG_LEN - 2) : 0);
  localparam logic [IW:0]   LEN_EXT  = (IW+1)'(MSG_LEN);
  localparam logic [PW-1:0] PRES_MAX = PW'(DIV - 1);

  logic [PW-1:0] pres_q, pres_d;
  logic [IW-1:0] pos_q,  pos_d;
  logic          bdir_q, bdir_d;   // 0 = up, 1 = down (bounce mode)
  logic          step_q, step_d;
  logic          wrap_q, wrap_d;

  logic          pres_last_s;
  logic          step_ev_s;
  logic          pos_oor_s;
  logic          load_ok_s;

  // Next-state logic: prescaler, load, and wrap/bounce position update.
  always_comb begin
    pres_d = pres_q;
    pos_d  = pos_q;
    bdir_d = bdir_q;
    step_d = 1'b0;
    wrap_d = 1'b0;

    pres_last_s = (pres_q == PRES_MAX);
    step_ev_s   = bus.En && pres_last_s;
    pos_oor_s   = ({1'b0, pos_q} >= LEN_EXT);
    load_ok_s   = ({1'b0, bus.LoadPos} < LEN_EXT);

    if (bus.En) begin
      if (pres_last_s) begin
        pres_d = '0;
      end else begin
        pres_d = pres_q + PW'(1);
      end
    end

    if (bus.Load) begin
      // Load wins over a coincident step: no Step/Wrap pulse, count restarts.
      pos_d  = load_ok_s ? bus.LoadPos : '0;
      pres_d = '0;
      bdir_d = bus.Dir;
    end else begin
      if (!bus.Bounce) begin
        bdir_d = bus.Dir;
      end
      if (step_ev_s) begin
        step_d = 1'b1;
        if (pos_oor_s) begin
          pos_d = '0;
        end else if (MSG_LEN == 1) begin
          pos_d  = '0;
          wrap_d = 1'b1;
        end else if (!bus.Bounce) begin
          if (!bus.Dir) begin
            if (pos_q == POS_LAST) begin
              pos_d  = '0;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q + IW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              pos_d  = POS_LAST;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q - IW'(1);
            end
          end
        end else begin
          if (!bdir_q) begin
            if (pos_q == POS_LAST) begin
              pos_d  = POS_TURN;
              bdir_d = 1'b1;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q + IW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              pos_d  = IW'(1);
              bdir_d = 1'b0;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q - IW'(1);
            end
          end
        end
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge Clock or posedge Clr) begin
    if (Clr) begin
      pres_q <= '0;
      pos_q  <= '0;
      bdir_q <= 1'b0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pres_q <= pres_d;
      pos_q  <= pos_d;
      bdir_q <= bdir_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  // Window slots: (Pos + k) mod MSG_LEN via one add and a conditional subtract;
  // the per-slot offset k mod MSG_LEN is an elaboration-time constant.
  logic [NUM_DISP*IW-1:0] win_s;
  for (genvar k = 0; k < NUM_DISP; k++) begin : g_slot
    localparam int KM = k % MSG_LEN;
    logic [IW:0] sum_s;
    logic [IW:0] red_s;
    assign sum_s = {1'b0, pos_q} + (IW+1)'(KM);
    assign red_s = (sum_s >= LEN_EXT) ? (sum_s - LEN_EXT) : sum_s;
    assign win_s[k*IW +: IW] = red_s[IW-1:0];
  end

  assign bus.Pos  = pos_q;
  assign bus.Win  = win_s;
  assign bus.Step = step_q;
  assign bus.Wrap = wrap_q;
endmodule

// File: tb/tb_scroll_window_gen.sv
// Directed + randomized bench for scroll_window_gen (MSG_LEN=5, NUM_DISP=4, DIV=4)
// against an integer behavioural model of the scroll rules.
module tb_scroll_window_gen;
  localparam int M  = 5;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int IW = 3;

  logic clk;
  logic clr;
  int   total;
  int   bad;

  // model state
  int   m_pos;
  int   m_pres;
  int   m_bdir;
  int   m_step;
  int   m_wrap;

  scroll_window_gen_if #(.MSG_LEN(M), .NUM_DISP(N)) sw_if ();

  scroll_window_gen #(.MSG_LEN(M), .NUM_DISP(N), .DIV(D)) dut (
    .Clock (clk),
    .Clr   (clr),
    .bus   (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*IW-1:0] exp_win(input int p);
    logic [N*IW-1:0] w;
    w = '0;
    for (int k = 0; k < N; k++) w[k*IW +: IW] = IW'((p + k) % M);
    return w;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_pres = 0; m_bdir = 0; m_step = 0; m_wrap = 0;
  endtask

  // Apply the scroll rules for one rising edge using the currently driven inputs.
  task automatic model_edge();
    int ev;
    if (sw_if.Load) begin
      m_pos  = (int'(sw_if.LoadPos) < M) ? int'(sw_if.LoadPos) : 0;
      m_pres = 0;
      m_bdir = int'(sw_if.Dir);
      m_step = 0;
      m_wrap = 0;
    end else begin
      ev = (sw_if.En && m_pres == D - 1) ? 1 : 0;
      if (sw_if.En) m_pres = (m_pres + 1) % D;
      m_step = ev;
      m_wrap = 0;
      if (ev != 0) begin
        if (!sw_if.Bounce) begin
          m_wrap = sw_if.Dir ? int'(m_pos == 0) : int'(m_pos == M - 1);
          m_pos  = (m_pos + (sw_if.Dir ? M - 1 : 1)) % M;
        end else if (m_bdir == 0) begin
          if (m_pos == M - 1) begin m_pos = M - 2; m_bdir = 1; m_wrap = 1; end
          else m_pos = m_pos + 1;
        end else begin
          if (m_pos == 0) begin m_pos = 1; m_bdir = 0; m_wrap = 1; end
          else m_pos = m_pos - 1;
        end
      end
      if (!sw_if.Bounce) m_bdir = int'(sw_if.Dir);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pos"},  32'(sw_if.Pos),  32'(m_pos));
    check({tag, ".step"}, 32'(sw_if.Step), 32'(m_step));
    check({tag, ".wrap"}, 32'(sw_if.Wrap), 32'(m_wrap));
    check({tag, ".win"},  32'(sw_if.Win),  32'(exp_win(m_pos)));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr   = 1'b1;
    sw_if.En = 1'b0; sw_if.Dir = 1'b0; sw_if.Bounce = 1'b0;
    sw_if.Load = 1'b0; sw_if.LoadPos = 3'd0;
    model_reset();
    #2;
    check_outputs("reset");
    check("reset.win_const", 32'(sw_if.Win), 32'(12'b011_010_001_000));
    clr = 1'b0;

    // wrap up
    sw_if.En = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick("wrap_up");
      if (m_pos == 3) check("wrap_up.win3", 32'(sw_if.Win), 32'(12'b001_000_100_011));
    end

    // async clear between edges with a non-zero position
    if (m_pos == 0) tick("pre_clr");
    while (m_pos == 0) tick("pre_clr");
    #2 clr = 1'b1;
    #1;
    model_reset();
    check_outputs("async_clr");
    #1 clr = 1'b0;

    // wrap down
    sw_if.Dir = 1'b1;
    for (int i = 0; i < 24; i++) tick("wrap_dn");

    // bounce from reset
    @(negedge clk) clr = 1'b1;
    #1 model_reset();
    check_outputs("clr2");
    clr = 1'b0;
    sw_if.Dir = 1'b0;
    sw_if.Bounce = 1'b1;
    for (int i = 0; i < 44; i++) tick("bounce");

    // pause at prescaler = 2
    for (int i = 0; i < D && m_pres != 2; i++) tick("to_pres2");
    check("pause.pres_reached", 32'(m_pres), 32'd2);
    sw_if.En = 1'b0;
    for (int i = 0; i < 10; i++) tick("pause");
    sw_if.En = 1'b1;
    tick("resume1");
    check("resume1.nostep", 32'(sw_if.Step), 32'd0);
    tick("resume2");
    check("resume2.step", 32'(sw_if.Step), 32'd1);

    // load coincident with a step event
    sw_if.Bounce = 1'b0;
    for (int i = 0; i < D && m_pres != 3; i++) tick("to_pres3");
    sw_if.Load = 1'b1; sw_if.LoadPos = 3'd2;
    tick("load_coinc");
    check("load_coinc.pos2", 32'(sw_if.Pos), 32'd2);
    sw_if.Load = 1'b0;
    for (int i = 0; i < 4; i++) tick("after_load");
    check("after_load.step", 32'(sw_if.Step), 32'd1);

    // out-of-range load
    sw_if.Load = 1'b1; sw_if.LoadPos = 3'd7;
    tick("load7");
    check("load7.pos0", 32'(sw_if.Pos), 32'd0);
    sw_if.Load = 1'b0;

    // load downward under bounce
    sw_if.Bounce = 1'b1; sw_if.Dir = 1'b1;
    sw_if.Load = 1'b1; sw_if.LoadPos = 3'd3;
    tick("load_bdn");
    sw_if.Load = 1'b0; sw_if.Dir = 1'b0;
    for (int i = 0; i < 4; i++) tick("bdn");
    check("bdn.pos2", 32'(sw_if.Pos), 32'd2);

    // randomized phase
    for (int i = 0; i < 600; i++) begin
      sw_if.En = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) sw_if.Bounce = ~sw_if.Bounce;
      if ($urandom_range(0, 29) == 0) sw_if.Dir = ~sw_if.Dir;
      sw_if.Load = ($urandom_range(0, 24) == 0);
      sw_if.LoadPos = 3'($urandom_range(0, 7));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
